// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Both ends of the link import this so timing and framing agree.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned DefaultBaudDiv = 56;
  localparam int unsigned DataBits       = 8;

  function automatic int unsigned frame_bits(input bit parity_en, input int unsigned stop_bits);
    return 32'(1 + DataBits + (parity_en ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..Div-1 while enabled and pulses wrap_o on the last count.
// Also suitable for mid-bit sampling on the receive side.
module uart_baud_cnt #(
  parameter int unsigned Div = 56
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first 8-bit frames with optional parity and 1-2 stop bits.
// All outputs are registered; the line idles at mark.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = DefaultBaudDiv,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] tx_data,
  input  logic       pi_flag,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       rs232_tx
);

  localparam logic [2:0] LastBit  = 3'(DataBits - 1);
  localparam logic       LastStop = 1'(STOP_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       parity_q, parity_d;
  logic       line_q, line_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic       accept;
  logic       wrap;

  assign accept = ready_q && pi_flag;

  uart_baud_cnt #(
    .Div (BAUD_DIV)
  ) u_baud_cnt (
    .clk_i  (sclk),
    .rst_i  (s_rst),
    .en_i   (state_q != StIdle),
    .clr_i  (accept),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;
    line_d     = line_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StStart;
          shift_d   = tx_data;
          parity_d  = (^tx_data) ^ PARITY_ODD;
          bit_idx_d = '0;
          line_d    = 1'b0;
          ready_d   = 1'b0;
        end
      end
      StStart: begin
        if (wrap) begin
          state_d = StData;
          line_d  = shift_q[0];
        end
      end
      StData: begin
        if (wrap) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q != LastBit) begin
            line_d = shift_q[1];
          end else if (PARITY_EN) begin
            state_d = StParity;
            line_d  = parity_q;
          end else begin
            state_d    = StStop;
            stop_idx_d = 1'b0;
            line_d     = 1'b1;
          end
        end
      end
      StParity: begin
        if (wrap) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
          line_d     = 1'b1;
        end
      end
      StStop: begin
        if (wrap) begin
          if (stop_idx_q == LastStop) begin
            state_d = StIdle;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        line_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign rs232_tx = line_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule
